// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered or first-word-fall-through read, fill count,
// programmable almost-full/almost-empty, sticky overflow/underflow and synchronous flush.
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_C = AW'(DEPTH);
  localparam logic [ASIZE:0] AF_C   = AW'(AFULL_TH);
  localparam logic [ASIZE:0] AE_C   = AW'(AEMPTY_TH);
  localparam logic [ASIZE:0] ONE    = AW'(1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic             wr_ok, rd_ok;

  // Flags come straight off the registered count, so they move with it.
  assign wfull         = (count == FULL_C);
  assign walmost_full  = (count >= AF_C);
  assign rempty        = (count == '0);
  assign ralmost_empty = (count <= AE_C);

  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ONE;
      if (rd_ok) rptr <= rptr + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (clr)   rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem[rptr[ASIZE-1:0]];
      end
      assign rdata = rdata_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one registered-read and one FWFT instance on shared stimulus,
// compared every cycle against a queue model plus directed literal checks.
module tb_sync_fifo_flags;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0, winc = 1'b0, rinc = 1'b0;
  logic [7:0] wdata = '0;

  logic       s_wfull, s_waf, s_rempty, s_rae, s_ov, s_un;
  logic [7:0] s_rdata;
  logic [4:0] s_count;
  logic       f_wfull, f_waf, f_rempty, f_rae, f_ov, f_un;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  int npass = 0, ntot = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wdata(wdata), .winc(winc),
    .wfull(s_wfull), .walmost_full(s_waf), .rinc(rinc), .rdata(s_rdata),
    .rempty(s_rempty), .ralmost_empty(s_rae), .count(s_count),
    .overflow(s_ov), .underflow(s_un));

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_fw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wdata(wdata), .winc(winc),
    .wfull(f_wfull), .walmost_full(f_waf), .rinc(rinc), .rdata(f_rdata),
    .rempty(f_rempty), .ralmost_empty(f_rae), .count(f_count),
    .overflow(f_ov), .underflow(f_un));

  // Reference: contents as a queue; everything else is derived from its size.
  logic [7:0] q[$];
  logic       m_ov = 1'b0, m_un = 1'b0;
  logic [7:0] m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_ov = 1'b0; m_un = 1'b0; m_rd = '0;
    end else if (clr) begin
      q.delete(); m_ov = 1'b0; m_un = 1'b0; m_rd = '0;
    end else begin
      int n;
      n = q.size();
      if (winc && n == DEPTH) m_ov = 1'b1;
      if (rinc && n == 0)     m_un = 1'b1;
      if (rinc && n > 0)      m_rd = q.pop_front();
      if (winc && n < DEPTH)  q.push_back(wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("count",   32'(s_count),  32'(n));
      chk("wfull",   32'(s_wfull),  32'(n == DEPTH));
      chk("waf",     32'(s_waf),    32'(n >= 12));
      chk("rempty",  32'(s_rempty), 32'(n == 0));
      chk("rae",     32'(s_rae),    32'(n <= 2));
      chk("ovf",     32'(s_ov),     32'(m_ov));
      chk("unf",     32'(s_un),     32'(m_un));
      chk("rdata",   32'(s_rdata),  32'(m_rd));
      chk("f_count", 32'(f_count),  32'(n));
      chk("f_flags", 32'({f_wfull, f_waf, f_rempty, f_rae, f_ov, f_un}),
          32'({n == DEPTH, n >= 12, n == 0, n <= 2, m_ov, m_un}));
      chk("f_rdata", 32'(f_rdata),  32'(n > 0 ? q[0] : 8'h00));
    end
  end

  // Inputs change 2 time units after an edge; returns 2 units after the accepting edge.
  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
    winc = w; rinc = r; clr = c; wdata = d;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    // 1: reset state
    drive(0, 0, 0, 0);
    chk("rst_rempty", 32'(s_rempty), 1); chk("rst_rae", 32'(s_rae), 1);
    chk("rst_count", 32'(s_count), 0);   chk("rst_wfull", 32'(s_wfull), 0);
    chk("rst_rdata", 32'(s_rdata), 0);   chk("rst_frdata", 32'(f_rdata), 0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 8'(i));
      if (i == 10) chk("waf_11", 32'(s_waf), 0);
      if (i == 11) chk("waf_12", 32'(s_waf), 1);
      if (i == 14) chk("wfull_15", 32'(s_wfull), 0);
    end
    chk("wfull_16", 32'(s_wfull), 1); chk("count_16", 32'(s_count), 16);
    drive(1, 0, 0, 8'hEE);
    chk("ovf_set", 32'(s_ov), 1); chk("count_ovf", 32'(s_count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("fw_head", 32'(f_rdata), 32'(i));
      drive(0, 1, 0, 0);
      chk("rd_order", 32'(s_rdata), 32'(i));
      if (i == 12) chk("rae_3", 32'(s_rae), 0);
      if (i == 13) chk("rae_2", 32'(s_rae), 1);
    end
    chk("drained", 32'(s_rempty), 1);
    chk("ovf_sticky", 32'(s_ov), 1);

    // 3: simultaneous at full and at empty
    drive(0, 0, 1, 0);
    chk("clr_ovf", 32'(s_ov), 0);
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'(8'h20 + i));
    drive(1, 1, 0, 8'h99);
    chk("full_rw_cnt", 32'(s_count), 15); chk("full_rw_ovf", 32'(s_ov), 1);
    chk("full_rw_rd", 32'(s_rdata), 32'h20);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0);
    chk("full_rw_last", 32'(s_rdata), 32'h2F);
    drive(1, 1, 0, 8'h77);
    chk("empty_rw_cnt", 32'(s_count), 1); chk("empty_rw_unf", 32'(s_un), 1);
    drive(0, 1, 0, 0);
    chk("empty_rw_rd", 32'(s_rdata), 32'h77);

    // 4: wrap-around
    drive(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 8'(i));
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 8'(8'h40 + i));
      if (i == 14) chk("wrap_nfull", 32'(s_wfull), 0);
    end
    chk("wrap_full", 32'(s_wfull), 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0);
      chk("wrap_rd", 32'(s_rdata), 32'(8'h40 + i));
    end

    // 5: async reset mid-cycle, flush, underflow hold
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'(8'h50 + i));
    winc = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(s_count), 0); chk("arst_rempty", 32'(s_rempty), 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'(8'h60 + i));
    drive(0, 0, 1, 0);
    chk("clr_count", 32'(s_count), 0); chk("clr_sticky", 32'({s_ov, s_un}), 0);
    drive(1, 0, 0, 8'h3C);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("unf_set", 32'(s_un), 1); chk("unf_hold", 32'(s_rdata), 32'h3C);
    drive(1, 1, 1, 8'h11);
    chk("clr_prio", 32'(s_count), 0); chk("clr_rdata", 32'(s_rdata), 0);

    // 6: FWFT fall-through
    drive(1, 0, 0, 8'hA5);
    chk("fw_empty", 32'(f_rempty), 0); chk("fw_data", 32'(f_rdata), 32'hA5);
    drive(0, 1, 0, 0);
    chk("fw_pop_empty", 32'(f_rempty), 1); chk("fw_pop_data", 32'(f_rdata), 0);

    // Random traffic alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      drive($urandom_range(99) < wp, $urandom_range(99) >= wp,
            $urandom_range(199) == 0, 8'($urandom));
    end
    drive(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
